fetch_request_unit: RTL and testbench

Owns the program counter and all memory requests for the single-cycle datapath. Sits directly upstream of the control unit: fetches the instruction word and presents it for decode. It uses the decoded jump/branch/jr/lw/sw/halt flags to choose the next PC. It sequences the data-memory access for loads and stores, and it latches processor halt.

---
 rtl/fetch_request_unit.sv | 127 ++++++++++++
 tb/tb_fetch_request_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_request_unit.sv
// Program counter, instruction fetch and load/store sequencing for the single-cycle datapath.
// Optional performance counters are enabled by defining FETCH_REQUEST_PERF_CNT_EN.
module fetch_request_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic        beq,
  input  logic        bne,
  input  logic        lw,
  input  logic        sw,
  input  logic        halt,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        dhit,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        retire,
`ifdef FETCH_REQUEST_PERF_CNT_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, MEM, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        take_branch;
  logic        in_fetch;
  logic        in_mem;

  assign in_fetch = (state == FETCH);
  assign in_mem   = (state == MEM);

  assign pc_plus4 = pc + 32'd4;
  assign imemREN  = in_fetch;
  assign imemaddr = pc;
  // During a memory access the decoder must keep seeing the load/store word.
  assign instr    = in_mem ? instr_q : imemload;
  assign dmemREN  = in_mem & lw;
  assign dmemWEN  = in_mem & sw;

  // Reset aborts whatever is in flight, so it also masks completion.
  assign retire = nRST & ((in_fetch & ihit & ~halt & ~(lw | sw)) | (in_mem & dhit));

  assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign take_branch = (beq & zero) | (bne & ~zero);

  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = rs_data;
    else if (jump | jal)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (take_branch)
      next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= FETCH;
      pc      <= PC_RESET;
      instr_q <= 32'd0;
      halted  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            if (halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else if (lw | sw) begin
              instr_q <= imemload;
              state   <= MEM;
            end else begin
              pc <= next_pc;
            end
          end
        end
        MEM: begin
          if (dhit) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_REQUEST_PERF_CNT_EN
  logic stall;

  // HALTED matches neither term, which freezes both counters there.
  assign stall = (in_fetch & ~ihit) | (in_mem & ~dhit);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      retired_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (retire)
        retired_cnt <= retired_cnt + 32'd1;
      if (stall)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed self-checking bench for fetch_request_unit; covers counters when
// FETCH_REQUEST_PERF_CNT_EN is defined.
module tb_fetch_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, jump, jal, jr, beq, bne, lw, sw, halt, zero, dhit;
  logic [31:0] imemload, rs_data;
  logic        imemREN, dmemREN, dmemWEN, retire, halted;
  logic [31:0] imemaddr, instr, pc_plus4;
`ifdef FETCH_REQUEST_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDIU = 32'h2401_0001;

  fetch_request_unit #(.PC_RESET(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr), .pc_plus4(pc_plus4),
    .jump(jump), .jal(jal), .jr(jr), .beq(beq), .bne(bne), .lw(lw), .sw(sw),
    .halt(halt), .zero(zero), .rs_data(rs_data), .dhit(dhit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .retire(retire),
`ifdef FETCH_REQUEST_PERF_CNT_EN
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    ihit = 0; jump = 0; jal = 0; jr = 0; beq = 0; bne = 0; lw = 0; sw = 0;
    halt = 0; zero = 0; dhit = 0; imemload = 32'd0; rs_data = 32'd0;
  endtask

  // One non-memory instruction fetched with ihit=1; checks retire and the new PC.
  task automatic exec(input string tag, input logic [31:0] word, input logic [31:0] exp_pc);
    ihit = 1; imemload = word;
    #1;
    chk({tag, "_retire"}, {31'd0, retire}, 32'd1);
    tick();
    chk({tag, "_pc"}, imemaddr, exp_pc);
    clear_in();
  endtask

  initial begin
    clear_in();
    nRST = 0;
    tick();
    tick();
    // Reset state
    chk("rst_imemREN", {31'd0, imemREN}, 32'd1);
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("rst_dmemWEN", {31'd0, dmemWEN}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    nRST = 1;

    // Straight-line ADDIU stream: 0 -> 4 -> 8 -> C
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imemaddr, 32'(4 * i));
      exec("seq", ADDIU, 32'(4 * (i + 1)));
    end
    // Stall: no ihit means no retire and PC holds
    #1;
    chk("stall_retire", {31'd0, retire}, 32'd0);
    tick();
    chk("stall_pc", imemaddr, 32'h0C);
    exec("to10", ADDIU, 32'h10);

    // BEQ taken backwards
    beq = 1; zero = 1;
    exec("beq_taken", 32'h1022_FFFE, 32'h0C);
    exec("back10", ADDIU, 32'h10);
    beq = 1; zero = 0;
    exec("beq_not", 32'h1022_FFFE, 32'h14);
    beq = 1; zero = 1;
    exec("beq_to10", 32'h1022_FFFE, 32'h10);
    bne = 1; zero = 0;
    exec("bne_taken", 32'h1422_FFFE, 32'h0C);

    // jr wins over jump
    jr = 1; jump = 1; rs_data = 32'h1000_0000;
    exec("jr_prio", 32'h0800_0040, 32'h1000_0000);
    jump = 1;
    exec("j_target", 32'h0800_0040, 32'h1000_0100);
    jr = 1; rs_data = 32'h0000_0200;
    exec("jr", 32'h0000_0008, 32'h200);
    jump = 1; jal = 1;
    #1;
    chk("jal_link", pc_plus4, 32'h204);
    exec("jal", 32'h0C00_0008, 32'h20);

    // LW at 0x20 with three dhit-low cycles
    ihit = 1; lw = 1; imemload = 32'h8C22_0004;
    #1;
    chk("lw_fetch_retire", {31'd0, retire}, 32'd0);
    chk("lw_fetch_dren", {31'd0, dmemREN}, 32'd0);
    tick();
    imemload = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_dren", {31'd0, dmemREN}, 32'd1);
      chk("lw_wait_iren", {31'd0, imemREN}, 32'd0);
      chk("lw_wait_instr", instr, 32'h8C22_0004);
      chk("lw_wait_retire", {31'd0, retire}, 32'd0);
      tick();
    end
    dhit = 1;
    #1;
    chk("lw_hit_dren", {31'd0, dmemREN}, 32'd1);
    chk("lw_hit_retire", {31'd0, retire}, 32'd1);
    tick();
    clear_in();
    chk("lw_next_pc", imemaddr, 32'h24);
    chk("lw_dren_drop", {31'd0, dmemREN}, 32'd0);

    // SW with ihit and dhit together in FETCH: only ihit honoured
    ihit = 1; dhit = 1; sw = 1; imemload = 32'hAC22_0004;
    #1;
    chk("sw_fetch_retire", {31'd0, retire}, 32'd0);
    tick();
    chk("sw_mem_wen", {31'd0, dmemWEN}, 32'd1);
    chk("sw_mem_retire", {31'd0, retire}, 32'd1);
    tick();
    clear_in();
    chk("sw_next_pc", imemaddr, 32'h28);

    // PC wrap at 2^32
    jr = 1; rs_data = 32'hFFFF_FFFC;
    exec("to_top", 32'h0, 32'hFFFF_FFFC);
    exec("wrap", ADDIU, 32'h0);
    exec("to4", ADDIU, 32'h4);

    // HALT: no retire, halted from next edge, requests held at 0
    ihit = 1; halt = 1;
    #1;
    chk("halt_retire", {31'd0, retire}, 32'd0);
    chk("halt_pre", {31'd0, halted}, 32'd0);
    tick();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = ~i[0]; lw = i[1]; sw = ~i[1];
      #1;
      chk("halt_reqs", {28'd0, imemREN, dmemREN, dmemWEN, retire}, 32'd0);
      chk("halt_pc", imemaddr, 32'h4);
      tick();
    end
    clear_in();
    nRST = 0;
    tick();
    nRST = 1;
    chk("unhalt_addr", imemaddr, 32'h0);
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_iren", {31'd0, imemREN}, 32'd1);

    // Reset mid-MEM aborts without retire
    ihit = 1; lw = 1; imemload = 32'h8C22_0004;
    tick();
    chk("abort_dren", {31'd0, dmemREN}, 32'd1);
    dhit = 1; nRST = 0;
    #1;
    chk("abort_retire", {31'd0, retire}, 32'd0);
    tick();
    nRST = 1;
    clear_in();
    chk("abort_dren_drop", {31'd0, dmemREN}, 32'd0);
    chk("abort_addr", imemaddr, 32'h0);

`ifdef FETCH_REQUEST_PERF_CNT_EN
    nRST = 0;
    tick();
    nRST = 1;
    chk("cnt_rst_ret", retired_cnt, 32'd0);
    chk("cnt_rst_stall", stall_cnt, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    ihit = 1; imemload = ADDIU;
    for (int i = 0; i < 4; i++) tick();
    lw = 1; imemload = 32'h8C22_0004;
    tick();
    ihit = 0;
    for (int i = 0; i < 4; i++) tick();
    dhit = 1;
    tick();
    clear_in();
    chk("cnt_retired", retired_cnt, 32'd5);
    chk("cnt_stall", stall_cnt, 32'd7);
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    ihit = 1; imemload = ADDIU;
    tick();
    chk("cnt_wrap", retired_cnt, 32'd0);
    halt = 1;
    tick();
    clear_in();
    for (int i = 0; i < 3; i++) tick();
    chk("cnt_freeze_ret", retired_cnt, 32'd0);
    chk("cnt_freeze_stall", stall_cnt, 32'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
